// File: rtl/cache_ctrl.sv
// Direct-mapped, read-only, one-byte-per-line cache controller with a blocking miss path.
// Hit answers two cycles after accept; a miss holds mem_req until mem_ack, then answers one cycle later.
module cache_ctrl #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic [10:0]      cpu_addr,
    output logic             cpu_ready,
    output logic             cpu_valid,
    output logic [7:0]       cpu_rdata,
    output logic             mem_req,
    output logic [10:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [7:0]       mem_rdata,
    input  logic             flush,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 11 - INDEX_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        MEM_WAIT = 2'd2,
        RESPOND  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [10:0]             req_addr_q, req_addr_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q [LINES];
    logic [7:0]              data_q [LINES];
    logic                    cpu_valid_q, cpu_valid_d;
    logic [7:0]              cpu_rdata_q, cpu_rdata_d;
    logic                    mem_req_q, mem_req_d;
    logic [10:0]             mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]        hit_q, hit_d;
    logic [CNT_W-1:0]        miss_q, miss_d;
    logic                    fill_we;

    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic                    lookup_hit;

    assign req_idx    = req_addr_q[INDEX_BITS-1:0];
    assign req_tag    = req_addr_q[10:INDEX_BITS];
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign cpu_ready  = (state_q == IDLE) && !flush;
    assign cpu_valid  = cpu_valid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        valid_d     = valid_q;
        cpu_valid_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        fill_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Flush wins over a same-cycle request; cpu_ready is already low.
                if (flush) begin
                    valid_d = '0;
                end else if (cpu_req) begin
                    req_addr_d = cpu_addr;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lookup_hit) begin
                    cpu_rdata_d = data_q[req_idx];
                    cpu_valid_d = 1'b1;
                    if (hit_q != CNT_MAX) hit_d = hit_q + CNT_W'(1);
                    state_d     = IDLE;
                end else begin
                    if (miss_q != CNT_MAX) miss_d = miss_q + CNT_W'(1);
                    mem_req_d  = 1'b1;
                    mem_addr_d = req_addr_q;
                    state_d    = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    fill_we          = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    mem_req_d        = 1'b0;
                    state_d          = RESPOND;
                end
            end
            RESPOND: begin
                cpu_rdata_d = data_q[req_idx];
                cpu_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            valid_q     <= '0;
            cpu_valid_q <= 1'b0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            valid_q     <= valid_d;
            cpu_valid_q <= cpu_valid_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

    // Tag and data storage need no reset: every line is gated by its valid bit.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[req_idx] <= mem_rdata;
            tag_q[req_idx]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: a response scoreboard queue plus per-step timing checks.
module tb_cache_ctrl;

    localparam int CNT_W = 8;  // narrow counters so saturation is reachable in a short run
    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    logic             clk = 1'b0;
    logic             reset;
    logic             cpu_req;
    logic [10:0]      cpu_addr;
    logic             cpu_ready;
    logic             cpu_valid;
    logic [7:0]       cpu_rdata;
    logic             mem_req;
    logic [10:0]      mem_addr;
    logic             mem_ack;
    logic [7:0]       mem_rdata;
    logic             flush;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    int checks   = 0;
    int failures = 0;
    logic [7:0]  exp_q [$];
    logic [31:0] exp_hits   = 0;
    logic [31:0] exp_misses = 0;

    cache_ctrl #(.INDEX_BITS(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .cpu_valid  (cpu_valid),
        .cpu_rdata  (cpu_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .flush      (flush),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (cpu_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {24'd0, cpu_rdata}, 32'hxxxx_xxxx);
            end else begin
                chk("rdata", {24'd0, cpu_rdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one time unit after the accept edge (controller then in lookup).
    task automatic do_req(input logic [10:0] addr);
        int n = 0;
        while (cpu_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", {31'd0, cpu_ready}, 32'd1);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        tick();
        cpu_req  = 1'b0;
    endtask

    task automatic expect_hit(input logic [10:0] addr, input logic [7:0] data, input bit quiet);
        exp_q.push_back(data);
        exp_hits = sat_inc(exp_hits);
        do_req(addr);
        if (!quiet) chk("hit_lookup_valid", {31'd0, cpu_valid}, 32'd0);
        tick();
        if (!quiet) begin
            chk("hit_valid", {31'd0, cpu_valid}, 32'd1);
            chk("hit_no_memreq", {31'd0, mem_req}, 32'd0);
        end
        tick();
        if (!quiet) begin
            chk("hit_pulse_end", {31'd0, cpu_valid}, 32'd0);
            chk("hit_count", {24'd0, hit_count}, exp_hits);
        end
    endtask

    task automatic expect_miss(input logic [10:0] addr, input logic [7:0] data, input int delay);
        exp_q.push_back(data);
        exp_misses = sat_inc(exp_misses);
        do_req(addr);
        tick();
        chk("miss_memreq", {31'd0, mem_req}, 32'd1);
        chk("miss_memaddr", {21'd0, mem_addr}, {21'd0, addr});
        chk("miss_count", {24'd0, miss_count}, exp_misses);
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("miss_hold", {20'd0, mem_req, mem_addr}, {20'd0, 1'b1, addr});
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        chk("fill_memreq_drop", {31'd0, mem_req}, 32'd0);
        chk("fill_no_valid_yet", {31'd0, cpu_valid}, 32'd0);
        tick();
        chk("respond_valid", {31'd0, cpu_valid}, 32'd1);
        tick();
        chk("respond_pulse_end", {31'd0, cpu_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0;
        mem_ack = 1'b0; mem_rdata = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, cpu_valid}, 32'd0);
        chk("rst_memreq", {31'd0, mem_req}, 32'd0);
        chk("rst_memaddr", {21'd0, mem_addr}, 32'd0);
        chk("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
        chk("rst_counts", {16'd0, hit_count, miss_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("ready_after_reset", {31'd0, cpu_ready}, 32'd1);

        // Cold miss, then hit after fill
        expect_miss(11'h123, 8'hA5, 3);
        expect_hit(11'h123, 8'hA5, 1'b0);

        // Conflict on index 3 evicts, then the original address misses again
        expect_miss(11'h133, 8'h5A, 1);
        expect_miss(11'h123, 8'hA6, 0);
        chk("conflict_misses", {24'd0, miss_count}, 32'd3);
        expect_hit(11'h123, 8'hA6, 1'b0);

        // Stray mem_ack while idle must not touch the line
        mem_ack = 1'b1; mem_rdata = 8'hFF;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        chk("stray_ack_memreq", {31'd0, mem_req}, 32'd0);
        expect_hit(11'h123, 8'hA6, 1'b0);

        // Flush beats a simultaneous request
        flush = 1'b1; cpu_req = 1'b1; cpu_addr = 11'h123;
        #1;
        chk("flush_ready_low", {31'd0, cpu_ready}, 32'd0);
        tick();
        flush = 1'b0; cpu_req = 1'b0;
        tick();
        chk("flush_not_accepted", {30'd0, cpu_valid, mem_req}, 32'd0);
        expect_miss(11'h123, 8'hC3, 2);

        // Reset in the middle of a miss
        do_req(11'h155);
        tick();
        chk("pre_reset_memreq", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_memreq_drop", {31'd0, mem_req}, 32'd0);
        chk("reset_counts", {16'd0, hit_count, miss_count}, 32'd0);
        exp_hits = 0; exp_misses = 0;
        tick();
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h77;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        chk("late_ack_ignored", {30'd0, cpu_valid, mem_req}, 32'd0);
        expect_miss(11'h155, 8'h11, 1);
        expect_miss(11'h123, 8'h3C, 1);
        chk("post_reset_misses", {24'd0, miss_count}, 32'd2);

        // Saturate the hit counter, then one more hit must not wrap
        for (int i = 0; i < int'(CNT_MAX) - 1; i++) expect_hit(11'h123, 8'h3C, 1'b1);
        expect_hit(11'h123, 8'h3C, 1'b0);
        chk("hit_at_max", {24'd0, hit_count}, CNT_MAX);
        expect_hit(11'h123, 8'h3C, 1'b0);
        chk("hit_saturated", {24'd0, hit_count}, CNT_MAX);

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4, giving the number of index bits; the cache holds 2^INDEX_BITS lines.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the hit and miss counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cpu_req, input, 1 bit: the CPU presents a read request.
REQ-006 SHALL have port cpu_addr, input, 11 bits: the request address.
REQ-007 SHALL have port cpu_ready, output, 1 bit: the controller can accept a request this cycle.
REQ-008 SHALL have port cpu_valid, output, 1 bit: a one-cycle pulse marking cpu_rdata valid.
REQ-009 SHALL have port cpu_rdata, output, 8 bits: the returned data byte.
REQ-010 SHALL have port mem_req, output, 1 bit: a request to backing memory.
REQ-011 SHALL have port mem_addr, output, 11 bits: the address of the line to fill.
REQ-012 SHALL have port mem_ack, input, 1 bit: backing memory returns data this cycle.
REQ-013 SHALL have port mem_rdata, input, 8 bits: the fill data.
REQ-014 SHALL have port flush, input, 1 bit: invalidate all lines.
REQ-015 SHALL have port hit_count, output, CNT_W bits: the number of hits.
REQ-016 SHALL have port miss_count, output, CNT_W bits: the number of misses.

Function
REQ-017 SHALL be a direct-mapped, read-only cache with one byte per line; index = cpu_addr[INDEX_BITS-1:0] and tag = cpu_addr[10:INDEX_BITS].
REQ-018 SHALL implement the FSM states IDLE, LOOKUP, MEM_WAIT and RESPOND.
REQ-019 SHALL drive cpu_ready combinationally as (state==IDLE && !flush).
REQ-020 SHALL accept a request on any edge where cpu_req && cpu_ready holds: it latches cpu_addr into req_addr and moves to LOOKUP.
REQ-021 SHALL handle a hit in LOOKUP (valid[idx] and tag[idx]==req tag) as follows: register cpu_rdata=data[idx], pulse cpu_valid, increment hit_count, and return to IDLE; cpu_valid is high 2 cycles after the accept edge.
REQ-022 SHALL handle a miss in LOOKUP as follows: increment miss_count, move to MEM_WAIT, and register mem_req=1 with mem_addr=req_addr.
REQ-023 SHALL hold mem_req and mem_addr stable in MEM_WAIT until mem_ack is sampled high.
REQ-024 SHALL, on mem_ack in MEM_WAIT, write data[idx]=mem_rdata, tag[idx]=req tag and valid[idx]=1, drop mem_req, and move to RESPOND.
REQ-025 SHALL, in RESPOND, register cpu_rdata=the filled byte, pulse cpu_valid for exactly one cycle, and return to IDLE.
REQ-026 SHALL ignore mem_ack outside MEM_WAIT.
REQ-027 SHALL ignore cpu_req outside IDLE; no queueing.
REQ-028 SHALL clear all valid bits in a single edge when flush is high in IDLE, with the state staying IDLE; flush has priority over a simultaneous cpu_req, which is not accepted.
REQ-029 SHALL ignore flush outside IDLE; the requester holds flush until cpu_ready-equivalent idle.
REQ-030 SHALL make hit_count and miss_count saturate at all-ones and never wrap.
REQ-031 SHALL keep cpu_valid at 0 in every cycle other than the response cycle; cpu_rdata holds its last value otherwise.
REQ-032 SHALL keep a miss to an index holding a different tag replacing that line; there is no write-back.

Reset
REQ-033 SHALL, on reset assertion and asynchronously, set the state to IDLE; set cpu_valid=0, mem_req=0, mem_addr=0, cpu_rdata=0 and hit_count=miss_count=0; and clear all valid bits.
REQ-034 SHALL, on reset during MEM_WAIT, drop mem_req immediately, and SHALL NOT write any line from a mem_ack arriving after reset.
REQ-035 SHALL make cpu_ready 1 on the first cycle after reset deassertion provided flush is 0.

Verification
REQ-036 SHALL cover a cold miss: request 0x123, mem_ack with 0xA5 after 3 cycles -> mem_req high with mem_addr=0x123, then cpu_valid with cpu_rdata=0xA5, miss_count=1.
REQ-037 SHALL cover a hit after fill: request 0x123 again -> cpu_valid 2 cycles after accept, cpu_rdata=0xA5, no mem_req, hit_count=1.
REQ-038 SHALL cover a conflict: 0x123 filled, then 0x133 (same index 3, different tag) -> miss; then 0x123 misses again; miss_count increments each time.
REQ-039 SHALL cover flush versus request: flush and cpu_req both high in IDLE -> cpu_ready=0, request not accepted, and the next request to 0x123 misses.
REQ-040 SHALL cover reset mid-miss: reset asserted in MEM_WAIT -> mem_req=0 at once and both counters 0; a late mem_ack is ignored and 0x123 misses afterwards.
REQ-041 SHALL cover saturation: preload hit_count to 0xFFFF via 65535 hits to the same address -> one further hit leaves hit_count at 0xFFFF.
